token_ctrl_multi: RTL and testbench

//  CH-channel clocked successor of the error-resilient token controller. Per channel:
//   4-phase Lreq/Lack and Rreq/Rack handshakes; a capture-enable pulse for the data latch;
//   a sample window for the shadow-latch error detector; dual-rail Err1/Err0 resolution.
//  A detected timing error delays forwarding by ERR_DELAY cycles and bumps a saturating
//   per-channel error counter. Sits between pipeline stages of the resilient datapath.

---
 rtl/token_ctrl_multi_pkg.sv | 27 ++
 rtl/token_ctrl_ch.sv | 113 +++++++++++
 rtl/token_ctrl_multi.sv | 48 ++++
 tb/tb_token_ctrl_multi.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/token_ctrl_multi_pkg.sv
// Shared definitions for the multi-channel token controller: FSM state codes,
// default parameters and the sizing helper for the per-channel delay/timeout timer.
package token_ctrl_multi_pkg;

  localparam int DEF_CH        = 4;
  localparam int DEF_ERR_DELAY = 2;
  localparam int DEF_SAMPLE_TO = 4;
  localparam int DEF_CNT_W     = 8;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_CAPTURE = 3'd1;
  localparam logic [STATE_W-1:0] ST_SAMPLE  = 3'd2;
  localparam logic [STATE_W-1:0] ST_RECOVER = 3'd3;
  localparam logic [STATE_W-1:0] ST_SEND    = 3'd4;
  localparam logic [STATE_W-1:0] ST_RTZ     = 3'd5;

  // One timer serves both the SAMPLE timeout and the RECOVER hold, so it must
  // count up to the larger of the two terminal values (value - 1).
  function automatic int tmr_width(input int err_delay, input int sample_to);
    int m;
    m = (err_delay > sample_to) ? err_delay : sample_to;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/token_ctrl_ch.sv
// One channel of the error-resilient token controller: handshake FSM, shared
// delay/timeout timer, sticky dual-rail fault flag and saturating error counter.
module token_ctrl_ch
  import token_ctrl_multi_pkg::*;
#(
  parameter int ERR_DELAY = DEF_ERR_DELAY,
  parameter int SAMPLE_TO = DEF_SAMPLE_TO,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lreq_i,
  output logic             lack_o,
  output logic             rreq_o,
  input  logic             rack_i,
  output logic             latch_en_o,
  output logic             sample_o,
  input  logic             err1_i,
  input  logic             err0_i,
  input  logic             err_clr_i,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             fault_o
);

  localparam int              TW         = tmr_width(ERR_DELAY, SAMPLE_TO);
  localparam logic [TW-1:0]   DELAY_LAST = TW'(ERR_DELAY - 1);
  localparam logic [TW-1:0]   TMO_LAST   = TW'(SAMPLE_TO - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lack_q, lack_d;
  logic               fault_q, fault_d;
  logic               err_hit;

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so no path can infer a latch.
    state_d = state_q;
    tmr_d   = tmr_q;
    err_hit = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (lreq_i && !lack_q) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_SAMPLE;
        tmr_d   = '0;
      end
      ST_SAMPLE: begin
        // A fault freezes the channel here until reset; both-high never resolves.
        if (!fault_q && !(err1_i && err0_i)) begin
          if (err0_i) begin
            state_d = ST_SEND;
          end else if (err1_i || (tmr_q == TMO_LAST)) begin
            state_d = ST_RECOVER;
            tmr_d   = '0;
            err_hit = 1'b1;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
      end
      ST_RECOVER: begin
        if (tmr_q == DELAY_LAST) state_d = ST_SEND;
        else                     tmr_d   = tmr_q + TW'(1);
      end
      ST_SEND: begin
        if (rack_i) state_d = ST_RTZ;
      end
      ST_RTZ: begin
        if (!rack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    fault_d = fault_q | ((state_q == ST_SAMPLE) & err1_i & err0_i);

    // Left return-to-zero runs independently of the right-side FSM.
    if (!lreq_i)                    lack_d = 1'b0;
    else if (state_q == ST_CAPTURE) lack_d = 1'b1;
    else                            lack_d = lack_q;

    if (err_clr_i)                  cnt_d = '0;
    else if (err_hit && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    else                            cnt_d = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
      lack_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the same pre-edge values.
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      lack_q  <= lack_d;
      fault_q <= fault_d;
    end
  end

  assign lack_o     = lack_q;
  assign rreq_o     = (state_q == ST_SEND);
  assign latch_en_o = (state_q == ST_CAPTURE);
  assign sample_o   = (state_q == ST_SAMPLE);
  assign err_cnt_o  = cnt_q;
  assign fault_o    = fault_q;

endmodule

// File: rtl/token_ctrl_multi.sv
// CH independent token-controller channels; every output is a per-channel slice,
// there is no shared arbitration or combining logic.
module token_ctrl_multi
  import token_ctrl_multi_pkg::*;
#(
  parameter int CH        = DEF_CH,
  parameter int ERR_DELAY = DEF_ERR_DELAY,
  parameter int SAMPLE_TO = DEF_SAMPLE_TO,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       Lreq,
  output logic [CH-1:0]       Lack,
  output logic [CH-1:0]       Rreq,
  input  logic [CH-1:0]       Rack,
  output logic [CH-1:0]       latch_en,
  output logic [CH-1:0]       sample,
  input  logic [CH-1:0]       Err1,
  input  logic [CH-1:0]       Err0,
  input  logic                err_clr,
  output logic [CH*CNT_W-1:0] err_cnt,
  output logic [CH-1:0]       fault
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    token_ctrl_ch #(
      .ERR_DELAY (ERR_DELAY),
      .SAMPLE_TO (SAMPLE_TO),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst),
      .lreq_i     (Lreq[i]),
      .lack_o     (Lack[i]),
      .rreq_o     (Rreq[i]),
      .rack_i     (Rack[i]),
      .latch_en_o (latch_en[i]),
      .sample_o   (sample[i]),
      .err1_i     (Err1[i]),
      .err0_i     (Err0[i]),
      .err_clr_i  (err_clr),
      .err_cnt_o  (err_cnt[i*CNT_W +: CNT_W]),
      .fault_o    (fault[i])
    );
  end

endmodule

// File: tb/tb_token_ctrl_multi.sv
// Self-checking bench for token_ctrl_multi: directed handshakes plus randomized
// multi-channel traffic scored against a transaction-level timing/count model.
module tb_token_ctrl_multi;

  localparam int CH        = 4;
  localparam int ERR_DELAY = 2;
  localparam int SAMPLE_TO = 4;
  localparam int CNT_W     = 8;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [CH-1:0]       lreq, lack, rreq, rack, latch_en, sample, err1, err0, fault;
  logic                err_clr;
  logic [CH*CNT_W-1:0] err_cnt;

  logic [0:0] s_lreq, s_lack, s_rreq, s_rack, s_latch, s_sample, s_err1, s_err0, s_fault;
  logic       s_clr;
  logic [1:0] s_cnt;

  token_ctrl_multi #(.CH(CH), .ERR_DELAY(ERR_DELAY), .SAMPLE_TO(SAMPLE_TO), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .Lreq(lreq), .Lack(lack), .Rreq(rreq), .Rack(rack),
    .latch_en(latch_en), .sample(sample), .Err1(err1), .Err0(err0),
    .err_clr(err_clr), .err_cnt(err_cnt), .fault(fault)
  );

  token_ctrl_multi #(.CH(1), .ERR_DELAY(ERR_DELAY), .SAMPLE_TO(SAMPLE_TO), .CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .Lreq(s_lreq), .Lack(s_lack), .Rreq(s_rreq), .Rack(s_rack),
    .latch_en(s_latch), .sample(s_sample), .Err1(s_err1), .Err0(s_err0),
    .err_clr(s_clr), .err_cnt(s_cnt), .fault(s_fault)
  );

  int checks   = 0;
  int failures = 0;
  int scen_table [8];
  int exp_cnt [CH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scenario 0 = clean (Err0), 1 = timing error (Err1), 2 = timeout (both low).
  function automatic int exp_latency(input int scen);
    return 2 + ((scen == 2) ? SAMPLE_TO : 1) + ((scen == 0) ? 0 : ERR_DELAY);
  endfunction

  // Drives tokens on the masked channels and scores each handshake against the model.
  task automatic run_tokens(input int n, input logic [CH-1:0] mask, input int rd_force,
                            input bit use_table);
    int  lphase [CH], rphase [CH], gap [CH], lcnt [CH], rcnt [CH];
    int  t0 [CH], t_ldrop [CH], t_rack [CH], t_rdrop [CH];
    int  issued [CH], lat_cnt [CH], scen [CH];
    bit  busy [CH];
    bit  all_done;
    int  cyc;
    cyc = 0;
    all_done = 1'b0;
    for (int c = 0; c < CH; c++) begin
      lphase[c] = 0; rphase[c] = 0; lcnt[c] = 0; rcnt[c] = 0;
      t0[c] = 0; t_ldrop[c] = 0; t_rack[c] = 0; t_rdrop[c] = -1;
      issued[c] = 0; lat_cnt[c] = 0; scen[c] = 0; busy[c] = 1'b0;
      gap[c] = c * 2 + int'($urandom_range(0, 3));
    end
    for (int step = 0; step < 3000 && !all_done; step++) begin
      @(negedge clk);
      cyc++;
      for (int c = 0; c < CH; c++) begin
        if (!mask[c]) continue;
        if (latch_en[c]) lat_cnt[c]++;
        if (busy[c]) begin
          if (cyc == t0[c] + 1)
            check($sformatf("latch_en_ch%0d", c), 64'(latch_en[c]), 64'(1));
          // left side
          if (lphase[c] == 1 && lack[c]) begin
            check($sformatf("lack_rise_ch%0d", c), 64'(cyc - t0[c]), 64'(2));
            lcnt[c] = int'($urandom_range(0, 3));
            lphase[c] = 2;
          end
          if (lphase[c] == 2) begin
            if (lcnt[c] == 0) begin
              lreq[c] = 1'b0;
              t_ldrop[c] = cyc;
              lphase[c] = 3;
            end else lcnt[c]--;
          end
          if (lphase[c] == 3 && cyc == t_ldrop[c] + 1) begin
            check($sformatf("lack_fall_ch%0d", c), 64'(lack[c]), 64'(0));
            lphase[c] = 4;
          end
          // right side
          if (rphase[c] == 0 && rreq[c]) begin
            check($sformatf("rreq_lat_ch%0d", c), 64'(cyc - t0[c]), 64'(exp_latency(scen[c])));
            rcnt[c] = (rd_force >= 0) ? rd_force : int'($urandom_range(0, 10));
            rphase[c] = 1;
          end
          if (rphase[c] == 1) begin
            if (rcnt[c] == 0) begin
              rack[c] = 1'b1;
              t_rack[c] = cyc;
              rphase[c] = 2;
            end else rcnt[c]--;
          end
          if (rphase[c] == 2 && cyc == t_rack[c] + 1) begin
            check($sformatf("rreq_fall_ch%0d", c), 64'(rreq[c]), 64'(0));
            rcnt[c] = (rd_force >= 0) ? rd_force : int'($urandom_range(0, 10));
            rphase[c] = 3;
          end
          if (rphase[c] == 3) begin
            if (rcnt[c] == 0) begin
              rack[c] = 1'b0;
              t_rdrop[c] = cyc;
              rphase[c] = 4;
            end else rcnt[c]--;
          end
          if (lphase[c] == 4 && rphase[c] == 4) begin
            busy[c] = 1'b0;
            gap[c] = int'($urandom_range(0, 3));
          end
        end else if (issued[c] < n && cyc > t_rdrop[c]) begin
          if (gap[c] == 0) begin
            scen[c] = use_table ? scen_table[issued[c]] : int'($urandom_range(0, 2));
            err0[c] = (scen[c] == 0);
            err1[c] = (scen[c] == 1);
            lreq[c] = 1'b1;
            t0[c] = cyc;
            lphase[c] = 1;
            rphase[c] = 0;
            busy[c] = 1'b1;
            issued[c]++;
            if (scen[c] != 0) exp_cnt[c] = (exp_cnt[c] < CNT_MAX) ? exp_cnt[c] + 1 : CNT_MAX;
          end else gap[c]--;
        end
      end
      all_done = 1'b1;
      for (int c = 0; c < CH; c++)
        if (mask[c] && (busy[c] || issued[c] < n)) all_done = 1'b0;
    end
    check("run_done", 64'(all_done), 64'(1));
    for (int c = 0; c < CH; c++) begin
      if (!mask[c]) continue;
      check($sformatf("latch_pulses_ch%0d", c), 64'(lat_cnt[c]), 64'(issued[c]));
      check($sformatf("err_cnt_ch%0d", c), 64'(err_cnt[c*CNT_W +: CNT_W]), 64'(exp_cnt[c]));
    end
  endtask

  // One error token on the CNT_W=2 instance, optionally with err_clr on the counting edge.
  task automatic small_err_token(input bit clr_hit);
    s_err1 = 1'b1;
    s_err0 = 1'b0;
    s_lreq = 1'b1;
    for (int i = 0; i < 20 && !s_sample[0]; i++) @(negedge clk);
    check("s_sample_seen", 64'(s_sample), 64'(1));
    s_clr = clr_hit;
    @(negedge clk);
    s_clr = 1'b0;
    s_lreq = 1'b0;
    for (int i = 0; i < 20 && !s_rreq[0]; i++) @(negedge clk);
    check("s_rreq_seen", 64'(s_rreq), 64'(1));
    s_rack = 1'b1;
    @(negedge clk);
    s_rack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    lreq = '1; rack = '0; err1 = '0; err0 = '0; err_clr = 1'b0;
    s_lreq = 1'b1; s_rack = '0; s_err1 = '0; s_err0 = '0; s_clr = 1'b0;
    for (int c = 0; c < CH; c++) exp_cnt[c] = 0;
    for (int i = 0; i < 8; i++) scen_table[i] = 0;

    // Reset held with Lreq high
    repeat (3) @(negedge clk);
    check("rst_lack", 64'(lack), 64'(0));
    check("rst_rreq", 64'(rreq), 64'(0));
    check("rst_latch_en", 64'(latch_en), 64'(0));
    check("rst_sample", 64'(sample), 64'(0));
    check("rst_fault", 64'(fault), 64'(0));
    check("rst_err_cnt", 64'(err_cnt), 64'(0));
    check("rst_small_cnt", 64'(s_cnt), 64'(0));
    lreq = '0;
    s_lreq = 1'b0;
    rst = 1'b1;

    // Clean token on ch0, Rack one cycle after Rreq
    scen_table[0] = 0;
    run_tokens(1, 4'b0001, 1, 1'b1);

    // Four tokens, three with Err1
    scen_table[0] = 1; scen_table[1] = 1; scen_table[2] = 0; scen_table[3] = 1;
    run_tokens(4, 4'b0001, 1, 1'b1);
    check("cnt_after_3_errors", 64'(err_cnt[CNT_W-1:0]), 64'(3));

    // Timeout path counts as an error
    scen_table[0] = 2;
    run_tokens(1, 4'b0001, 2, 1'b1);
    check("cnt_after_timeout", 64'(err_cnt[CNT_W-1:0]), 64'(4));

    // Synchronous clear of all counters
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr_all", 64'(err_cnt), 64'(0));
    for (int c = 0; c < CH; c++) exp_cnt[c] = 0;

    // Both rails high on ch1: sticky fault, channel halts in SAMPLE
    err1[1] = 1'b1; err0[1] = 1'b1; lreq[1] = 1'b1;
    for (int i = 0; i < 20 && !sample[1]; i++) @(negedge clk);
    check("fault_sample_seen", 64'(sample[1]), 64'(1));
    @(negedge clk);
    check("fault_set", 64'(fault[1]), 64'(1));
    repeat (6) @(negedge clk);
    check("fault_rreq_low", 64'(rreq[1]), 64'(0));
    check("fault_still_sample", 64'(sample[1]), 64'(1));
    check("fault_other_ch", 64'(fault & 4'b1101), 64'(0));
    rst = 1'b0;
    #1;
    check("fault_cleared_by_rst", 64'(fault), 64'(0));
    lreq = '0; err1 = '0; err0 = '0;
    @(negedge clk);
    rst = 1'b1;

    // Saturation and clear-over-increment on the CNT_W=2 instance
    small_err_token(1'b0);
    small_err_token(1'b0);
    check("small_cnt_2", 64'(s_cnt), 64'(2));
    small_err_token(1'b0);
    small_err_token(1'b0);
    small_err_token(1'b0);
    check("small_cnt_sat", 64'(s_cnt), 64'(3));
    small_err_token(1'b1);
    check("small_clr_from_sat", 64'(s_cnt), 64'(0));
    small_err_token(1'b1);
    check("small_clr_wins", 64'(s_cnt), 64'(0));

    // Randomized independent traffic on all channels
    run_tokens(6, 4'b1111, -1, 1'b0);

    // Asynchronous reset in the middle of SEND
    @(negedge clk);
    err0 = '1; err1 = '0; rack = '0; lreq = '1;
    for (int i = 0; i < 20 && rreq != 4'hF; i++) @(negedge clk);
    check("midsend_rreq_all", 64'(rreq), 64'(4'hF));
    #2;
    rst = 1'b0;
    #1;
    check("midsend_rreq", 64'(rreq), 64'(0));
    check("midsend_lack", 64'(lack), 64'(0));
    check("midsend_latch_sample", 64'({latch_en, sample}), 64'(0));
    check("midsend_fault", 64'(fault), 64'(0));
    check("midsend_err_cnt", 64'(err_cnt), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
